itlb_assoc: RTL and testbench

Parametrised fully-associative instruction TLB sitting between the fetch PC stage and the page table walker, successor to the single-entry pass-through ITLB. Holds NUM_ENTRIES VPN→PPN translations with execute permission and gives a registered hit/miss result one cycle after a lookup. Runs a miss-request/refill handshake with the walker and selects victims by first-invalid, then round-robin. An optional ASID tag lets translations survive context switches without a full flush.

---
 rtl/itlb_assoc_if.sv | 40 ++++
 rtl/itlb_assoc.sv | 237 +++++++++++++++++++++++
 tb/tb_itlb_assoc.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/itlb_assoc_if.sv
// itlb_assoc_if: lookup, flush and walker-refill signals of the instruction TLB.
// The slave modport is the TLB side; the master modport is the fetch/walker side.
interface itlb_assoc_if #(
   parameter int VPN_WIDTH  = 20,
   parameter int PPN_WIDTH  = 20,
   parameter int ASID_WIDTH = 9
);
   logic                  i_stall;
   logic                  i_flush;
   logic                  i_read;
   logic [VPN_WIDTH-1:0]  i_vpn;
   logic [ASID_WIDTH-1:0] i_asid;
   logic                  o_avail;
   logic                  o_hit;
   logic [PPN_WIDTH-1:0]  o_ppn;
   logic                  o_exec;
   logic                  o_busy;
   logic                  o_miss_req;
   logic [VPN_WIDTH-1:0]  o_miss_vpn;
   logic                  i_miss_ack;
   logic                  i_refill_valid;
   logic [PPN_WIDTH-1:0]  i_refill_ppn;
   logic                  i_refill_exec;
   logic                  i_refill_fault;
   logic                  o_refill_fault;

   modport slave (
      input  i_stall, i_flush, i_read, i_vpn, i_asid,
      input  i_miss_ack, i_refill_valid, i_refill_ppn, i_refill_exec, i_refill_fault,
      output o_avail, o_hit, o_ppn, o_exec, o_busy,
      output o_miss_req, o_miss_vpn, o_refill_fault
   );

   modport master (
      output i_stall, i_flush, i_read, i_vpn, i_asid,
      output i_miss_ack, i_refill_valid, i_refill_ppn, i_refill_exec, i_refill_fault,
      input  o_avail, o_hit, o_ppn, o_exec, o_busy,
      input  o_miss_req, o_miss_vpn, o_refill_fault
   );
endinterface

// File: rtl/itlb_assoc.sv
// itlb_assoc: fully-associative instruction TLB with a registered lookup result,
// a miss-request/refill handshake towards the page table walker, and
// first-invalid-then-round-robin victim selection.
// Optional feature macro: ITLB_ASID_EN adds a per-entry ASID tag that is
// captured at miss time and compared on lookup.
module itlb_assoc #(
   parameter int NUM_ENTRIES = 8,
   parameter int VPN_WIDTH   = 20,
   parameter int PPN_WIDTH   = 20,
   parameter int ASID_WIDTH  = 9
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   itlb_assoc_if.slave bus
);
   localparam int IDX_W = $clog2(NUM_ENTRIES);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2
   } state_e;

   state_e                 state_q, state_d;
   logic [NUM_ENTRIES-1:0] valid_q, valid_d;
   logic [VPN_WIDTH-1:0]   vpn_q  [NUM_ENTRIES];
   logic [VPN_WIDTH-1:0]   vpn_d  [NUM_ENTRIES];
   logic [PPN_WIDTH-1:0]   ppn_q  [NUM_ENTRIES];
   logic [PPN_WIDTH-1:0]   ppn_d  [NUM_ENTRIES];
   logic [NUM_ENTRIES-1:0] exec_q, exec_d;

   logic                   avail_q, avail_d;
   logic                   hit_q, hit_d;
   logic [PPN_WIDTH-1:0]   res_ppn_q, res_ppn_d;
   logic                   res_exec_q, res_exec_d;
   logic [VPN_WIDTH-1:0]   lookup_vpn_q, lookup_vpn_d;
   logic [VPN_WIDTH-1:0]   miss_vpn_q, miss_vpn_d;
   logic [IDX_W-1:0]       rr_q, rr_d;
   logic                   refill_fault_q, refill_fault_d;

`ifdef ITLB_ASID_EN
   logic [ASID_WIDTH-1:0]  asid_q [NUM_ENTRIES];
   logic [ASID_WIDTH-1:0]  asid_d [NUM_ENTRIES];
   logic [ASID_WIDTH-1:0]  lookup_asid_q, lookup_asid_d;
   logic [ASID_WIDTH-1:0]  miss_asid_q, miss_asid_d;
`else
   logic                   unused_asid;
   assign unused_asid = ^bus.i_asid;
`endif

   logic                   busy;
   logic                   lookup_accept;
   logic [NUM_ENTRIES-1:0] entry_match;
   logic                   hit_any;
   logic [IDX_W-1:0]       hit_idx;
   logic                   have_invalid;
   logic [IDX_W-1:0]       free_idx;
   logic [IDX_W-1:0]       victim_idx;

   assign busy          = (state_q != IDLE);
   assign lookup_accept = bus.i_read && !bus.i_stall && !busy && !bus.i_flush;
   assign victim_idx    = have_invalid ? free_idx : rr_q;

   // Per-entry tag compare against the incoming lookup.
   always_comb begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
`ifdef ITLB_ASID_EN
         entry_match[i] = valid_q[i] && (vpn_q[i] == bus.i_vpn) && (asid_q[i] == bus.i_asid);
`else
         entry_match[i] = valid_q[i] && (vpn_q[i] == bus.i_vpn);
`endif
      end
   end

   // Priority-encode the matches; scanning downwards lets the lowest index win a multi-hit.
   always_comb begin
      hit_any = 1'b0;
      hit_idx = '0;
      for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
         if (entry_match[i]) begin
            hit_any = 1'b1;
            hit_idx = IDX_W'(i);
         end
      end
   end

   // Find the lowest-index invalid entry, preferred over the round-robin victim.
   always_comb begin
      have_invalid = 1'b0;
      free_idx     = '0;
      for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
         if (!valid_q[i]) begin
            have_invalid = 1'b1;
            free_idx     = IDX_W'(i);
         end
      end
   end

   // Next-state for the result registers, refill FSM and entry array; flush overrides everything.
   always_comb begin
      state_d        = state_q;
      valid_d        = valid_q;
      vpn_d          = vpn_q;
      ppn_d          = ppn_q;
      exec_d         = exec_q;
      avail_d        = avail_q;
      hit_d          = hit_q;
      res_ppn_d      = res_ppn_q;
      res_exec_d     = res_exec_q;
      lookup_vpn_d   = lookup_vpn_q;
      miss_vpn_d     = miss_vpn_q;
      rr_d           = rr_q;
      refill_fault_d = 1'b0;
`ifdef ITLB_ASID_EN
      asid_d         = asid_q;
      lookup_asid_d  = lookup_asid_q;
      miss_asid_d    = miss_asid_q;
`endif

      if (bus.i_flush) begin
         avail_d = 1'b0;
      end else if (bus.i_stall) begin
         avail_d = avail_q;
      end else if (lookup_accept) begin
         avail_d      = 1'b1;
         hit_d        = hit_any;
         res_ppn_d    = hit_any ? ppn_q[hit_idx] : '0;
         res_exec_d   = hit_any ? exec_q[hit_idx] : 1'b0;
         lookup_vpn_d = bus.i_vpn;
`ifdef ITLB_ASID_EN
         lookup_asid_d = bus.i_asid;
`endif
      end else begin
         avail_d = 1'b0;
      end

      if (bus.i_flush) begin
         state_d = IDLE;
         valid_d = '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (avail_q && !hit_q) begin
                  state_d    = REQ;
                  miss_vpn_d = lookup_vpn_q;
`ifdef ITLB_ASID_EN
                  miss_asid_d = lookup_asid_q;
`endif
               end
            end
            REQ: begin
               if (bus.i_miss_ack) begin
                  state_d = WAIT;
               end
            end
            WAIT: begin
               if (bus.i_refill_valid) begin
                  state_d = IDLE;
                  if (bus.i_refill_fault) begin
                     refill_fault_d = 1'b1;
                  end else begin
                     valid_d[victim_idx] = 1'b1;
                     vpn_d[victim_idx]   = miss_vpn_q;
                     ppn_d[victim_idx]   = bus.i_refill_ppn;
                     exec_d[victim_idx]  = bus.i_refill_exec;
`ifdef ITLB_ASID_EN
                     asid_d[victim_idx]  = miss_asid_q;
`endif
                     if (!have_invalid) begin
                        rr_d = rr_q + IDX_W'(1);
                     end
                  end
               end
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   // State and storage registers with asynchronous active-low reset.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q        <= IDLE;
         valid_q        <= '0;
         exec_q         <= '0;
         for (int i = 0; i < NUM_ENTRIES; i++) begin
            vpn_q[i] <= '0;
            ppn_q[i] <= '0;
`ifdef ITLB_ASID_EN
            asid_q[i] <= '0;
`endif
         end
         avail_q        <= 1'b0;
         hit_q          <= 1'b0;
         res_ppn_q      <= '0;
         res_exec_q     <= 1'b0;
         lookup_vpn_q   <= '0;
         miss_vpn_q     <= '0;
         rr_q           <= '0;
         refill_fault_q <= 1'b0;
`ifdef ITLB_ASID_EN
         lookup_asid_q  <= '0;
         miss_asid_q    <= '0;
`endif
      end else begin
         state_q        <= state_d;
         valid_q        <= valid_d;
         exec_q         <= exec_d;
         vpn_q          <= vpn_d;
         ppn_q          <= ppn_d;
`ifdef ITLB_ASID_EN
         asid_q         <= asid_d;
         lookup_asid_q  <= lookup_asid_d;
         miss_asid_q    <= miss_asid_d;
`endif
         avail_q        <= avail_d;
         hit_q          <= hit_d;
         res_ppn_q      <= res_ppn_d;
         res_exec_q     <= res_exec_d;
         lookup_vpn_q   <= lookup_vpn_d;
         miss_vpn_q     <= miss_vpn_d;
         rr_q           <= rr_d;
         refill_fault_q <= refill_fault_d;
      end
   end

   assign bus.o_avail        = avail_q;
   assign bus.o_hit          = hit_q;
   assign bus.o_ppn          = res_ppn_q;
   assign bus.o_exec         = res_exec_q;
   assign bus.o_busy         = busy;
   assign bus.o_miss_req     = (state_q == REQ);
   assign bus.o_miss_vpn     = miss_vpn_q;
   assign bus.o_refill_fault = refill_fault_q;
endmodule

// File: tb/tb_itlb_assoc.sv
// tb_itlb_assoc: scoreboard bench for itlb_assoc; a reference TLB model predicts
// each lookup result, which is queued at issue and compared when o_avail rises.
module tb_itlb_assoc;
   localparam int N  = 8;
   localparam int VW = 20;
   localparam int PW = 20;
   localparam int AW = 9;

   typedef struct packed {
      logic          hit;
      logic [PW-1:0] ppn;
      logic          exec;
   } result_t;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   itlb_assoc_if #(.VPN_WIDTH(VW), .PPN_WIDTH(PW), .ASID_WIDTH(AW)) bus ();

   itlb_assoc #(
      .NUM_ENTRIES(N),
      .VPN_WIDTH  (VW),
      .PPN_WIDTH  (PW),
      .ASID_WIDTH (AW)
   ) dut (
      .i_clk  (clk),
      .i_rst_n(rst_n),
      .bus    (bus)
   );

   // Free-running clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference model state.
   logic          mValid [N];
   logic [VW-1:0] mVpn   [N];
   logic [PW-1:0] mPpn   [N];
   logic          mExec  [N];
   logic [AW-1:0] mAsid  [N];
   int            mRr;
   result_t       sbQ[$];

   function automatic result_t modelLookup(input logic [VW-1:0] vpn, input logic [AW-1:0] asid);
      result_t r;
      r = '0;
      for (int i = N - 1; i >= 0; i--) begin
`ifdef ITLB_ASID_EN
         if (mValid[i] && mVpn[i] == vpn && mAsid[i] == asid) begin
`else
         if (mValid[i] && mVpn[i] == vpn) begin
`endif
            r.hit  = 1'b1;
            r.ppn  = mPpn[i];
            r.exec = mExec[i];
         end
      end
      return r;
   endfunction

   task automatic modelRefill(input logic [VW-1:0] vpn, input logic [AW-1:0] asid,
                              input logic [PW-1:0] ppn, input logic exec);
      int v;
      v = -1;
      for (int i = 0; i < N; i++) begin
         if (!mValid[i] && v < 0) v = i;
      end
      if (v < 0) begin
         v   = mRr;
         mRr = (mRr + 1) % N;
      end
      mValid[v] = 1'b1;
      mVpn[v]   = vpn;
      mPpn[v]   = ppn;
      mExec[v]  = exec;
      mAsid[v]  = asid;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Issue one lookup; returns at the negedge of the result cycle with i_read low.
   task automatic applyStimulus(input logic [VW-1:0] vpn, input logic [AW-1:0] asid);
      result_t r;
      sbQ.push_back(modelLookup(vpn, asid));
      bus.i_read = 1'b1;
      bus.i_vpn  = vpn;
      bus.i_asid = asid;
      @(negedge clk);
      bus.i_read = 1'b0;
      checkOutput("avail", {31'd0, bus.o_avail}, 32'd1);
      if (sbQ.size() > 0) begin
         r = sbQ.pop_front();
         checkOutput("hit",  {31'd0, bus.o_hit},  {31'd0, r.hit});
         checkOutput("ppn",  {12'd0, bus.o_ppn},  {12'd0, r.ppn});
         checkOutput("exec", {31'd0, bus.o_exec}, {31'd0, r.exec});
      end
   endtask

   // Lookup that must miss, followed by the full walker handshake.
   task automatic doMiss(input logic [VW-1:0] vpn, input logic [AW-1:0] asid,
                         input logic [PW-1:0] ppn, input logic exec, input logic fault);
      int wait_cycles;
      applyStimulus(vpn, asid);
      checkOutput("missHit", {31'd0, bus.o_hit}, 32'd0);
      @(negedge clk);
      checkOutput("availDrop", {31'd0, bus.o_avail}, 32'd0);
      wait_cycles = 0;
      while (!bus.o_miss_req && wait_cycles < 20) begin
         @(negedge clk);
         wait_cycles++;
      end
      checkOutput("missReqLatency", wait_cycles, 0);
      checkOutput("missReq", {31'd0, bus.o_miss_req}, 32'd1);
      checkOutput("missVpn", {12'd0, bus.o_miss_vpn}, {12'd0, vpn});
      checkOutput("busyReq", {31'd0, bus.o_busy}, 32'd1);
      bus.i_miss_ack = 1'b1;
      @(negedge clk);
      bus.i_miss_ack = 1'b0;
      checkOutput("waitNoReq", {31'd0, bus.o_miss_req}, 32'd0);
      checkOutput("busyWait", {31'd0, bus.o_busy}, 32'd1);
      bus.i_refill_valid = 1'b1;
      bus.i_refill_ppn   = ppn;
      bus.i_refill_exec  = exec;
      bus.i_refill_fault = fault;
      @(negedge clk);
      bus.i_refill_valid = 1'b0;
      bus.i_refill_fault = 1'b0;
      checkOutput("busyDone", {31'd0, bus.o_busy}, 32'd0);
      checkOutput("faultPulse", {31'd0, bus.o_refill_fault}, {31'd0, fault});
      if (!fault) modelRefill(vpn, asid, ppn, exec);
      @(negedge clk);
      checkOutput("faultPulseEnd", {31'd0, bus.o_refill_fault}, 32'd0);
   endtask

   // Overall time limit so the run always ends.
   initial begin
      #500000;
      $display("[TB] FAIL timeout observed running expected finished");
      $fatal(1, "[TB] timeout");
   end

   // Main test sequence.
   initial begin
      checks = 0;
      errors = 0;
      mRr    = 0;
      for (int i = 0; i < N; i++) begin
         mValid[i] = 1'b0; mVpn[i] = '0; mPpn[i] = '0; mExec[i] = 1'b0; mAsid[i] = '0;
      end
      rst_n              = 1'b0;
      bus.i_stall        = 1'b0;
      bus.i_flush        = 1'b0;
      bus.i_read         = 1'b0;
      bus.i_vpn          = '0;
      bus.i_asid         = '0;
      bus.i_miss_ack     = 1'b0;
      bus.i_refill_valid = 1'b0;
      bus.i_refill_ppn   = '0;
      bus.i_refill_exec  = 1'b0;
      bus.i_refill_fault = 1'b0;
      @(negedge clk);
      @(negedge clk);
      checkOutput("rstAvail", {31'd0, bus.o_avail}, 32'd0);
      checkOutput("rstHit", {31'd0, bus.o_hit}, 32'd0);
      checkOutput("rstPpn", {12'd0, bus.o_ppn}, 32'd0);
      checkOutput("rstExec", {31'd0, bus.o_exec}, 32'd0);
      checkOutput("rstBusy", {31'd0, bus.o_busy}, 32'd0);
      checkOutput("rstMissReq", {31'd0, bus.o_miss_req}, 32'd0);
      checkOutput("rstMissVpn", {12'd0, bus.o_miss_vpn}, 32'd0);
      checkOutput("rstFault", {31'd0, bus.o_refill_fault}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // First miss and refill into entry 0, then re-lookup hits.
      doMiss(20'h12345, 9'd0, 20'h00ABC, 1'b1, 1'b0);
      applyStimulus(20'h12345, 9'd0);
      checkOutput("refillHit", {31'd0, bus.o_hit}, 32'd1);
      checkOutput("refillPpn", {12'd0, bus.o_ppn}, 32'h00ABC);
      checkOutput("refillExec", {31'd0, bus.o_exec}, 32'd1);

      // Stall holds the result and blocks a new lookup.
      bus.i_stall = 1'b1;
      bus.i_read  = 1'b1;
      bus.i_vpn   = 20'h0F0F0;
      @(negedge clk);
      checkOutput("stallAvail", {31'd0, bus.o_avail}, 32'd1);
      checkOutput("stallPpn", {12'd0, bus.o_ppn}, 32'h00ABC);
      bus.i_stall = 1'b0;
      bus.i_read  = 1'b0;
      @(negedge clk);
      checkOutput("postStallAvail", {31'd0, bus.o_avail}, 32'd0);
      checkOutput("postStallBusy", {31'd0, bus.o_busy}, 32'd0);

      // Stray refill and ack while idle must not change anything.
      bus.i_refill_valid = 1'b1;
      bus.i_miss_ack     = 1'b1;
      bus.i_refill_ppn   = 20'h5A5A5;
      @(negedge clk);
      bus.i_refill_valid = 1'b0;
      bus.i_miss_ack     = 1'b0;
      @(negedge clk);
      checkOutput("strayBusy", {31'd0, bus.o_busy}, 32'd0);
      checkOutput("strayFault", {31'd0, bus.o_refill_fault}, 32'd0);

      // Fill entries 1..7.
      for (int i = 1; i < N; i++) begin
         doMiss(VW'(32'h100 + i), 9'd0, PW'(32'h200 + i), i[0], 1'b0);
      end
      applyStimulus(20'h00107, 9'd0);
      checkOutput("fullHit7", {12'd0, bus.o_ppn}, 32'h207);

      // Ninth and tenth VPNs evict entries 0 and 1 round-robin.
      doMiss(20'h00999, 9'd0, 20'h00909, 1'b1, 1'b0);
      doMiss(20'h00AAA, 9'd0, 20'h00A0A, 1'b0, 1'b0);
      doMiss(20'h12345, 9'd0, 20'h0, 1'b0, 1'b1);
      doMiss(20'h00101, 9'd0, 20'h0, 1'b0, 1'b1);
      applyStimulus(20'h00999, 9'd0);
      checkOutput("evictHit999", {12'd0, bus.o_ppn}, 32'h909);
      applyStimulus(20'h00102, 9'd0);
      checkOutput("keepHit102", {31'd0, bus.o_hit}, 32'd1);

      // Flush coincident with refill in WAIT discards the refill and clears all entries.
      applyStimulus(20'h00555, 9'd0);
      @(negedge clk);
      checkOutput("flushReq", {31'd0, bus.o_miss_req}, 32'd1);
      bus.i_miss_ack = 1'b1;
      @(negedge clk);
      bus.i_miss_ack     = 1'b0;
      bus.i_refill_valid = 1'b1;
      bus.i_refill_ppn   = 20'h00777;
      bus.i_flush        = 1'b1;
      @(negedge clk);
      bus.i_refill_valid = 1'b0;
      bus.i_flush        = 1'b0;
      checkOutput("flushBusy", {31'd0, bus.o_busy}, 32'd0);
      checkOutput("flushFault", {31'd0, bus.o_refill_fault}, 32'd0);
      checkOutput("flushAvail", {31'd0, bus.o_avail}, 32'd0);
      for (int i = 0; i < N; i++) mValid[i] = 1'b0;
      doMiss(20'h00999, 9'd0, 20'h0, 1'b0, 1'b1);
      doMiss(20'h00102, 9'd0, 20'h0, 1'b0, 1'b1);
      doMiss(20'h00555, 9'd0, 20'h0, 1'b0, 1'b1);

`ifdef ITLB_ASID_EN
      // ASID tag separates identical VPNs.
      doMiss(20'h00001, 9'd3, 20'h00333, 1'b1, 1'b0);
      doMiss(20'h00001, 9'd4, 20'h0, 1'b0, 1'b1);
      applyStimulus(20'h00001, 9'd3);
      checkOutput("asidHit", {31'd0, bus.o_hit}, 32'd1);
      checkOutput("asidPpn", {12'd0, bus.o_ppn}, 32'h333);
`endif

      @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
